// File: rtl/mem_stage.sv
// Memory-access stage: word-addressed data RAM with fixed access latency, stalling
// upstream while an access is in flight, ending in the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoRegIn,
    input  logic        RegWriteIn,
    input  logic [3:0]  writeRegIn,
    input  logic [15:0] resultALUIn,
    input  logic [15:0] writeDataIn,
    output logic        stall,
    output logic        valid_out,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic [3:0]  writeReg,
    output logic [15:0] dataReadMEM,
    output logic [15:0] resultALU
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        rw;
        logic [3:0]  wreg;
        logic [15:0] alu;
        logic [15:0] wdata;
    } op_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_t               in_op, lat_q, src;
    logic              mem_op, commit, latch_en;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       ram [DEPTH];

    assign mem_op = valid_in & (MemRead | MemWrite);

    always_comb begin
        in_op = '{rd: MemRead, wr: MemWrite, m2r: MemtoRegIn, rw: RegWriteIn,
                  wreg: writeRegIn, alu: resultALUIn, wdata: writeDataIn};
        // While waiting, the latched copy is authoritative; live inputs are ignored.
        src  = (state_q == StWait) ? lat_q : in_op;
        addr = src.alu[ADDR_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit   = 1'b0;
        latch_en = 1'b0;
        stall    = 1'b0;
        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    if (LATENCY == 1) begin
                        commit = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        latch_en = 1'b1;
                        state_d  = StWait;
                        cnt_d    = CNT_W'(1);
                    end
                end
            end
            StWait: begin
                if (cnt_q < CNT_LAST) begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    commit  = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (reset) stall = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) lat_q <= in_op;
        end
    end

    always_ff @(posedge clock) begin
        if (commit && src.wr) ram[addr] <= src.wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_out   <= 1'b0;
            MemtoReg    <= 1'b0;
            RegWrite    <= 1'b0;
            writeReg    <= '0;
            dataReadMEM <= '0;
            resultALU   <= '0;
        end else if (commit) begin
            valid_out   <= 1'b1;
            MemtoReg    <= src.m2r;
            RegWrite    <= src.rw;
            writeReg    <= src.wreg;
            // Non-blocking read returns the pre-write word when read and write coincide.
            dataReadMEM <= src.rd ? ram[addr] : 16'h0000;
            resultALU   <= src.alu;
        end else if (state_q == StIdle && !mem_op) begin
            valid_out   <= valid_in;
            MemtoReg    <= MemtoRegIn;
            RegWrite    <= RegWriteIn;
            writeReg    <= writeRegIn;
            dataReadMEM <= '0;
            resultALU   <= resultALUIn;
        end else begin
            valid_out   <= 1'b0;
            MemtoReg    <= 1'b0;
            RegWrite    <= 1'b0;
            writeReg    <= '0;
            dataReadMEM <= '0;
            resultALU   <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance at LATENCY=2 and one at LATENCY=1 share stimulus.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in, MemRead, MemWrite, MemtoRegIn, RegWriteIn;
    logic [3:0]  writeRegIn;
    logic [15:0] resultALUIn, writeDataIn;

    logic        stall, valid_out, MemtoReg, RegWrite;
    logic [3:0]  writeReg;
    logic [15:0] dataReadMEM, resultALU;

    logic        stall_1, valid_out_1, MemtoReg_1, RegWrite_1;
    logic [3:0]  writeReg_1;
    logic [15:0] dataReadMEM_1, resultALU_1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    mem_stage #(.DEPTH(256), .LATENCY(2)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoRegIn(MemtoRegIn), .RegWriteIn(RegWriteIn),
        .writeRegIn(writeRegIn), .resultALUIn(resultALUIn), .writeDataIn(writeDataIn),
        .stall(stall), .valid_out(valid_out), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .writeReg(writeReg), .dataReadMEM(dataReadMEM), .resultALU(resultALU)
    );

    mem_stage #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .valid_in(valid_in), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoRegIn(MemtoRegIn), .RegWriteIn(RegWriteIn),
        .writeRegIn(writeRegIn), .resultALUIn(resultALUIn), .writeDataIn(writeDataIn),
        .stall(stall_1), .valid_out(valid_out_1), .MemtoReg(MemtoReg_1),
        .RegWrite(RegWrite_1), .writeReg(writeReg_1), .dataReadMEM(dataReadMEM_1),
        .resultALU(resultALU_1)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic [3:0] wreg, input logic [15:0] alu,
                         input logic [15:0] wdata);
        valid_in    = v;
        MemRead     = rd;
        MemWrite    = wr;
        MemtoRegIn  = m2r;
        RegWriteIn  = rw;
        writeRegIn  = wreg;
        resultALUIn = alu;
        writeDataIn = wdata;
    endtask

    // One memory op through the LATENCY=2 instance: stall one cycle, one bubble, commit.
    task automatic mem2(input string tag, input logic rd, input logic wr, input logic m2r,
                        input logic [15:0] alu, input logic [15:0] wdata,
                        input logic [15:0] exp_rd);
        drive(1'b1, rd, wr, m2r, rd, 4'h3, alu, wdata);
        #1;
        check({tag, " stall_accept"}, stall, 1'b1);
        tick();
        check({tag, " bubble_valid"}, valid_out, 1'b0);
        check({tag, " stall_wait"}, stall, 1'b0);
        tick();
        check({tag, " commit_valid"}, valid_out, 1'b1);
        check({tag, " commit_m2r"}, MemtoReg, m2r);
        check({tag, " commit_alu"}, resultALU, alu);
        if (rd) check({tag, " commit_data"}, dataReadMEM, exp_rd);
    endtask

    logic [16:0] l1_tab [4];

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        tick();
        tick();
        check("rst_valid", valid_out, 1'b0);
        check("rst_alu", resultALU, 16'h0000);
        check("rst_data", dataReadMEM, 16'h0000);
        check("rst_stall", stall, 1'b0);
        reset = 1'b0;

        // Pass-through ALU op
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 16'h0003, 16'h0000);
        #1;
        check("pt_stall", stall, 1'b0);
        tick();
        check("pt_alu", resultALU, 16'h0003);
        check("pt_wreg", {12'h000, writeReg}, 16'h0002);
        check("pt_rw", RegWrite, 1'b1);
        check("pt_valid", valid_out, 1'b1);
        check("pt_m2r", MemtoReg, 1'b0);

        // Reset mid-WAIT discards the pending store
        mem2("pre", 1'b0, 1'b1, 1'b0, 16'h0005, 16'h1111, 16'h0000);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0005, 16'h00AA);
        tick();
        check("l1_pre_rst_valid", valid_out_1, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_l1_valid", valid_out_1, 1'b0);
        check("rst_l1_alu", resultALU_1, 16'h0000);
        check("rst_l1_rw_wreg", {11'h000, RegWrite_1, writeReg_1}, 16'h0000);
        check("rst_l1_m2r", MemtoReg_1, 1'b0);
        check("rst_mid_valid", valid_out, 1'b0);
        check("rst_mid_stall", stall, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        tick();
        reset = 1'b0;
        mem2("rst_ld", 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000, 16'h1111);

        // Store then load, with wrap-around and simultaneous read/write
        mem2("st10", 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0001, 16'h0000);
        mem2("ld10", 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0001);
        mem2("st_wrap", 1'b0, 1'b1, 1'b0, 16'h0105, 16'hBEEF, 16'h0000);
        mem2("ld_wrap", 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000, 16'hBEEF);
        mem2("st7", 1'b0, 1'b1, 1'b0, 16'h0007, 16'h1234, 16'h0000);
        mem2("rw7", 1'b1, 1'b1, 1'b1, 16'h0007, 16'h5678, 16'h1234);
        mem2("ld7", 1'b1, 1'b0, 1'b1, 16'h0007, 16'h0000, 16'h5678);

        // LATENCY=1 back-to-back: {is_store, data}; addresses 0x20,0x20,0x21,0x21
        l1_tab[0] = {1'b1, 16'hA0A0};
        l1_tab[1] = {1'b0, 16'hA0A0};
        l1_tab[2] = {1'b1, 16'hB1B1};
        l1_tab[3] = {1'b0, 16'hB1B1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ~l1_tab[i][16], l1_tab[i][16], 1'b0, 1'b0, 4'h0,
                  16'h0020 + 16'(i / 2), l1_tab[i][15:0]);
            #1;
            check($sformatf("l1_stall_%0d", i), stall_1, 1'b0);
            tick();
            check($sformatf("l1_valid_%0d", i), valid_out_1, 1'b1);
            if (!l1_tab[i][16]) check($sformatf("l1_data_%0d", i), dataReadMEM_1, l1_tab[i][15:0]);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipeline, between EX and WB. It owns the word-addressed data RAM and performs loads and stores with a configurable access latency, stalling upstream while an access is in flight. It ends in the MEM/WB pipeline register whose outputs drive the WB stage directly: `MemtoReg`, `dataReadMEM`, `resultALU`, plus register-write control.

## Interface
- `DEPTH`, default 256: data RAM words, a power of two; `ADDR_W = log2(DEPTH)`.
- `LATENCY`, default 2: cycles a memory op occupies the stage, ≥1.

Ports:
- `clock`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  EX/MEM holds a valid instruction.
- `MemRead`  in  1  load.
- `MemWrite`  in  1  store.
- `MemtoRegIn`  in  1  WB select, passed through.
- `RegWriteIn`  in  1  register write enable, passed through.
- `writeRegIn`  in  4  destination register, passed through.
- `resultALUIn`  in  16  ALU result; also the memory address, word index `resultALUIn[ADDR_W-1:0]`.
- `writeDataIn`  in  16  store data.
- `stall`  out  1  combinational; upstream must hold EX/MEM while high.
- `valid_out`  out  1  MEM/WB holds a valid instruction.
- `MemtoReg`  out  1  to WB.
- `RegWrite`  out  1  to WB.
- `writeReg`  out  4  to WB.
- `dataReadMEM`  out  16  load data to WB.
- `resultALU`  out  16  ALU result to WB.

## Operation
- Memory op: `valid_in & (MemRead | MemWrite)`. Otherwise the instruction is non-memory; `valid_in=0` is a bubble.
- FSM states: IDLE and WAIT. Cycle counter `cnt` has width `clog2(LATENCY)+1`.
- IDLE, non-memory op or bubble:
  - `stall=0`.
  - At the next edge, MEM/WB loads the pass-through fields with `valid_out=valid_in`.
  - `dataReadMEM` loads 0.
- IDLE, memory op, `LATENCY=1`:
  - `stall=0`.
  - Commits at the next edge (see commit).
- IDLE, memory op, `LATENCY>1`:
  - `stall=1`.
  - At the edge, latch all inputs, go to WAIT with `cnt=1`.
  - MEM/WB loads a bubble: `valid_out=0` and all fields 0.
- WAIT:
  - Inputs are ignored; the latched copy is used.
  - `stall = (cnt < LATENCY-1)`.
  - Each edge with `cnt < LATENCY-1`: `cnt++`, MEM/WB loads a bubble.
  - Edge with `cnt == LATENCY-1`: commit, then go to IDLE.
- Commit edge:
  - Store: `RAM[addr] <= writeData`.
  - Load: `dataReadMEM <= RAM[addr]`.
  - The remaining MEM/WB fields take the op's values, `valid_out=1`.
- `MemRead & MemWrite` together:
  - Treated as a store.
  - `dataReadMEM` returns the pre-write word (read-before-write).
- Address bits above `ADDR_W` are ignored, so addresses wrap modulo `DEPTH`.
- A store commits before the next instruction is accepted. A load immediately after a store to the same address returns the new data.
- RAM is not reset; contents are undefined until written.

## Timing
- Reset, asynchronous, any state:
  - FSM to IDLE, `cnt=0`, latched op discarded.
  - Any pending store is not performed.
  - All outputs 0: `valid_out`, `MemtoReg`, `RegWrite`, `writeReg`, `dataReadMEM`, `resultALU`.
  - `stall=0` while reset is high.
- Latency, acceptance edge to MEM/WB valid:
  - Non-memory op: 1 edge.
  - Memory op: `LATENCY` edges.
- Bubbles inserted into WB per memory op: `LATENCY-1`.
- Throughput: non-memory ops 1 per cycle; memory ops 1 per `LATENCY` cycles.
- A new instruction is accepted in the cycle after commit; commit and acceptance never share an edge.
- MEM/WB outputs change only on rising edges. `stall` depends on the FSM, `cnt`, `valid_in`, `MemRead` and `MemWrite` only.

## Test plan
- **Reset:** assert `reset` mid-WAIT during a store of 16'h00AA to address 5 (`LATENCY=2`).
  - Outputs 0 immediately.
  - A later load of address 5 does not return 16'h00AA. Preload 16'h1111; the load returns 16'h1111.
- **Pass-through:** ALU op with `resultALUIn=16'h0003`, `RegWriteIn=1`, `writeRegIn=4'h2`, `MemtoRegIn=0`.
  - One edge later: `resultALU=16'h0003`, `writeReg=2`, `RegWrite=1`, `valid_out=1`, `stall=0`.
- **Store then load, `LATENCY=2`:** store 16'h0001 to address 16'h0010, then load 16'h0010 with `MemtoRegIn=1`.
  - `stall` is high exactly 1 cycle per op.
  - Load commit gives `dataReadMEM=16'h0001`, `MemtoReg=1`, `valid_out=1`.
  - One bubble (`valid_out=0`) precedes each commit.
- **Wrap-around:** store 16'hBEEF to `resultALUIn=16'h0105` (`DEPTH=256`), then load 16'h0005.
  - Load returns 16'hBEEF.
- **Simultaneous read/write:** address 7 holds 16'h1234; issue `MemRead=MemWrite=1` with data 16'h5678.
  - `dataReadMEM=16'h1234`.
  - A later load of 7 returns 16'h5678.
- **`LATENCY=1` back-to-back:** four alternating stores and loads.
  - `stall` never asserts.
  - `valid_out=1` on every cycle after the first edge.
